// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
// Latency: n/a; backpressure: n/a.
package tdm_demux_pkg;

  `include "tdm_defs.vh"

  localparam int TDM_SEL_W_DEF = 2;

  typedef logic [0:0] state_t;

endpackage

// File: rtl/tdm_demux_if.sv
// Link-side bus of the TDM demux: shared sample input plus fanned-out channel outputs.
// Latency: n/a; backpressure: none, the link has no ready path.
interface tdm_demux_if
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH    = TDM_WIDTH_DEF,
  parameter int CHANNELS = TDM_CHANNELS_DEF,
  parameter int SEL_W    = TDM_SEL_W_DEF
) ();

  logic [WIDTH-1:0]          I;
  logic                      I_valid;
  logic                      sof;
  logic [CHANNELS*WIDTH-1:0] Y;
  logic [CHANNELS-1:0]       Y_valid;
  logic [SEL_W-1:0]          S;
  logic                      frame_done;
  logic                      sync_err;
  logic                      locked;

  modport master (
    output I, I_valid, sof,
    input  Y, Y_valid, S, frame_done, sync_err, locked
  );

  modport slave (
    input  I, I_valid, sof,
    output Y, Y_valid, S, frame_done, sync_err, locked
  );

endinterface

// File: rtl/tdm_defs.vh
// State encodings and default sizing shared by the TDM demux and its companion mux/tx block.
// Included inside a package or module scope so the names stay local to that scope.
localparam logic [0:0] ST_HUNT          = 1'b0;
localparam logic [0:0] ST_LOCK          = 1'b1;
localparam int         TDM_WIDTH_DEF    = 4;
localparam int         TDM_CHANNELS_DEF = 4;

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear, load-to-1, increment wrapping at CHANNELS-1, with a last-slot flag.
// Latency: slot updates one edge after the command; backpressure: none.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = TDM_CHANNELS_DEF,
  parameter int SEL_W    = TDM_SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [SEL_W-1:0] slot,
  output logic             last_slot
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] slot_q;
  logic [SEL_W-1:0] slot_d;

  assign last_slot = (slot_q == LAST);
  assign slot      = slot_q;

  // Explicit wrap keeps non-power-of-two channel counts from reaching slot values >= CHANNELS.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SEL_W'(1);
    end else if (inc) begin
      slot_d = last_slot ? '0 : slot_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// 1:CHANNELS time-division demux with sof-based frame alignment (HUNT/LOCK) and held channel registers.
// Latency: sample accepted at edge n is on Y with its Y_valid pulse right after edge n; backpressure: none.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH    = TDM_WIDTH_DEF,
  parameter int CHANNELS = TDM_CHANNELS_DEF,
  parameter int SEL_W    = TDM_SEL_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  state_t              state_q;
  state_t              state_d;
  logic [WIDTH-1:0]    ch_q [CHANNELS];
  logic [WIDTH-1:0]    ch_d [CHANNELS];
  logic [CHANNELS-1:0] y_valid_q;
  logic [CHANNELS-1:0] y_valid_d;
  logic                frame_done_q;
  logic                frame_done_d;
  logic                sync_err_q;
  logic                sync_err_d;

  logic                cnt_clr;
  logic                cnt_load1;
  logic                cnt_inc;
  logic                last_slot;
  logic [SEL_W-1:0]    slot;
  logic                wr_en;
  logic [SEL_W-1:0]    wr_idx;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_slot_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .load1     (cnt_load1),
    .inc       (cnt_inc),
    .slot      (slot),
    .last_slot (last_slot)
  );

  // A valid sof always realigns to slot 0; it is only an error if LOCK expected a later slot.
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_load1    = 1'b0;
    cnt_inc      = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = slot;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (bus.I_valid) begin
      if (bus.sof) begin
        wr_en      = 1'b1;
        wr_idx     = '0;
        cnt_load1  = 1'b1;
        state_d    = ST_LOCK;
        sync_err_d = (state_q == ST_LOCK) && (slot != '0);
      end else if (state_q == ST_LOCK) begin
        if (slot == '0) begin
          sync_err_d = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = ST_HUNT;
        end else begin
          wr_en        = 1'b1;
          cnt_inc      = 1'b1;
          frame_done_d = last_slot;
        end
      end
    end
  end

  always_comb begin
    y_valid_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      ch_d[k] = ch_q[k];
      if (wr_en && (wr_idx == SEL_W'(k))) begin
        ch_d[k]      = bus.I;
        y_valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      y_valid_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        ch_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      y_valid_q    <= y_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      for (int k = 0; k < CHANNELS; k++) begin
        ch_q[k] <= ch_d[k];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_y
    assign bus.Y[g*WIDTH +: WIDTH] = ch_q[g];
  end

  assign bus.Y_valid    = y_valid_q;
  assign bus.S          = slot;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == ST_LOCK);

endmodule
